vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator.
- Samples the active-low `h_sync`/`v_sync` and the `bright` strobe, then recovers pixel coordinates and line/frame boundaries from them.
- Checks the stream against nominal 640x480 timing and reports lock and errors.
- Sits downstream of the generator: pixel/game-render logic consumes its coordinates, and self-check logic consumes its lock and error flags.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/vga_sync_decoder.sv | 199 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and the decoder lock-state encoding.
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_SYNC   = 96;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_BACK   = 48;

    localparam int V_TOTAL  = 525;
    localparam int V_SYNC   = 2;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_BACK   = 33;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-stage capture of an active-low sync input with a falling-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic low_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    // Capture pipeline; both stages idle high so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= sync_i;
            s2_q <= s1_q;
        end
    end

    assign low_o  = !s1_q;
    assign fall_o = s2_q && !s1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame boundaries from VGA sync/bright,
// measures line timing against nominal values and reports lock and errors.
//
// state   | meaning
// SEARCH  | no reference h_sync fall yet; line length unknown
// MEASURE | counting consecutive conforming lines towards lock
// LOCKED  | timing conforms; violations pulse err_line
module vga_sync_decoder #(
    parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int LOCK_LINES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             bright,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_valid,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic [CNT_W-1:0] line_period,
    output logic             err_line
);
    import vga_timing_pkg::*;

    localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] SYNC_C    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] ACTIVE_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(2 * H_TOTAL);
    localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_LINES);
    localparam logic [CNT_W-1:0] ONES_C    = '1;
    localparam logic [CNT_W-1:0] ZERO_C    = '0;

    logic h_low, h_fall, v_fall, v_low_unused;
    logic br_s1_q, br_s2_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] hs_w_q, hs_w_d;
    logic [CNT_W-1:0] act_w_q, act_w_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic [CNT_W-1:0] line_period_q, line_period_d;
    logic [CNT_W-1:0] match_q, match_d, match_inc;
    logic [CNT_W-1:0] line_len;
    logic             line_start_q, frame_start_q, err_q, err_d;
    logic             conform, timeout, pix_valid_c;
    lock_state_e      state_q, state_d;

    sync_edge_detect u_hs (
        .clk    (clk),
        .reset  (reset),
        .sync_i (h_sync),
        .low_o  (h_low),
        .fall_o (h_fall)
    );

    sync_edge_detect u_vs (
        .clk    (clk),
        .reset  (reset),
        .sync_i (v_sync),
        .low_o  (v_low_unused),
        .fall_o (v_fall)
    );

    // Line measurement, coordinate counters and the conformance verdict.
    always_comb begin
        line_len    = h_cnt_q + 1'b1;
        conform     = (line_len == TOTAL_C) && (hs_w_q == SYNC_C)
                      && ((act_w_q == ZERO_C) || (act_w_q == ACTIVE_C));
        timeout     = !h_fall && (state_q != SEARCH) && (h_cnt_q == TIMEOUT_C);
        pix_valid_c = br_s2_q && (state_q == LOCKED);
        match_inc   = match_q + 1'b1;

        h_cnt_d = (h_cnt_q == ONES_C) ? h_cnt_q : h_cnt_q + 1'b1;
        hs_w_d  = (h_low && hs_w_q != ONES_C) ? hs_w_q + 1'b1 : hs_w_q;
        act_w_d = (br_s2_q && act_w_q != ONES_C) ? act_w_q + 1'b1 : act_w_q;
        pix_x_d = (pix_valid_c && pix_x_q != ONES_C) ? pix_x_q + 1'b1 : pix_x_q;
        pix_y_d = pix_y_q;
        line_period_d = line_period_q;

        if (h_fall) begin
            // The fall cycle already belongs to the new line.
            h_cnt_d = ZERO_C;
            hs_w_d  = {{(CNT_W-1){1'b0}}, h_low};
            act_w_d = {{(CNT_W-1){1'b0}}, br_s2_q};
            pix_x_d = ZERO_C;
            if (act_w_q != ZERO_C) begin
                pix_y_d = pix_y_q + 1'b1;
            end
            if (state_q != SEARCH) begin
                line_period_d = line_len;
            end
        end
        if (v_fall) begin
            pix_y_d = ZERO_C;
        end
    end

    // Lock FSM: next state, match counter and error pulse.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_d   = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (h_fall) begin
                    state_d = MEASURE;
                    match_d = ZERO_C;
                end
            end
            MEASURE: begin
                if (h_fall) begin
                    if (conform) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = ZERO_C;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                    match_d = ZERO_C;
                end
            end
            LOCKED: begin
                if (h_fall) begin
                    if (!conform) begin
                        err_d   = 1'b1;
                        state_d = MEASURE;
                        match_d = ZERO_C;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                    match_d = ZERO_C;
                end
            end
            default: begin
                state_d = SEARCH;
                match_d = ZERO_C;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and registered pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            br_s1_q       <= 1'b0;
            br_s2_q       <= 1'b0;
            h_cnt_q       <= '0;
            hs_w_q        <= '0;
            act_w_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_period_q <= '0;
            match_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            br_s1_q       <= bright;
            br_s2_q       <= br_s1_q;
            h_cnt_q       <= h_cnt_d;
            hs_w_q        <= hs_w_d;
            act_w_q       <= act_w_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_period_q <= line_period_d;
            match_q       <= match_d;
            line_start_q  <= h_fall;
            frame_start_q <= v_fall;
            err_q         <= err_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_c;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign line_period = line_period_q;
    assign err_line    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench: line-level stream generator plus a line-level lock/coordinate model.
module tb_vga_sync_decoder;

    localparam int CNT_W      = 16;
    localparam int LOCK_LINES = 4;
    localparam int LINE_NOM   = 800;
    localparam int SYNC_NOM   = 96;
    localparam int ACT_NOM    = 640;
    localparam int ACT_START  = 144;

    logic             clk, reset, h_sync, v_sync, bright;
    logic [CNT_W-1:0] pix_x, pix_y, line_period;
    logic             pix_valid, line_start, frame_start, locked, err_line;

    vga_sync_decoder #(
        .H_TOTAL(LINE_NOM), .H_SYNC(SYNC_NOM), .H_ACTIVE(ACT_NOM),
        .LOCK_LINES(LOCK_LINES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .bright(bright),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .line_period(line_period),
        .err_line(err_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        bit lck;
        bit err;
        int y;
        bit fs;
    } ev_t;

    typedef struct {
        int first_x;
        int len;
        bit ok;
        int y;
    } run_t;

    int checks, errors;

    // Line-level model state
    bit m_have_prev;
    int m_run;
    int m_prev_len, m_prev_sw, m_prev_act;
    bit m_prev_vs;
    int m_y, m_period, m_err_total, m_fs_total;

    ev_t  exp_q[$], obs_q[$];
    run_t exp_run_q[$], obs_run_q[$];
    int   obs_err_cnt, obs_fs_cnt;

    // Event logger: records line_start snapshots, pulse counts and pixel runs.
    initial begin : monitor
        bit   in_run;
        run_t r;
        int   last_x;
        ev_t  o;
        in_run = 0;
        obs_err_cnt = 0;
        obs_fs_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_run = 0;
            end else begin
                if (line_start) begin
                    o.period = int'(line_period);
                    o.lck = locked;
                    o.err = err_line;
                    o.y = int'(pix_y);
                    o.fs = frame_start;
                    obs_q.push_back(o);
                end
                if (err_line) obs_err_cnt++;
                if (frame_start) obs_fs_cnt++;
                if (pix_valid) begin
                    if (!in_run) begin
                        in_run = 1;
                        r.first_x = int'(pix_x);
                        r.len = 1;
                        r.ok = 1;
                        r.y = int'(pix_y);
                    end else begin
                        r.len++;
                        if (int'(pix_x) != last_x + 1) r.ok = 0;
                    end
                    last_x = int'(pix_x);
                end else if (in_run) begin
                    in_run = 0;
                    obs_run_q.push_back(r);
                end
            end
        end
    end

    task automatic model_reset();
        m_have_prev = 0;
        m_run = 0;
        m_prev_len = 0;
        m_prev_sw = 0;
        m_prev_act = 0;
        m_prev_vs = 1;
        m_y = 0;
        m_period = 0;
    endtask

    // Predicts what the decoder reports at the h_sync fall that opens this line.
    task automatic model_line_start(input int len, input int sw, input int act, input bit vs);
        ev_t e;
        bit  conf, vfall;
        vfall = m_prev_vs && !vs;
        e.err = 0;
        if (m_have_prev) begin
            conf = (m_prev_len == LINE_NOM) && (m_prev_sw == SYNC_NOM)
                   && (m_prev_act == 0 || m_prev_act == ACT_NOM);
            m_period = m_prev_len;
            if (conf) begin
                m_run++;
            end else begin
                if (m_run >= LOCK_LINES) begin
                    e.err = 1;
                    m_err_total++;
                end
                m_run = 0;
            end
        end else begin
            m_have_prev = 1;
            m_run = 0;
        end
        if (vfall) begin
            m_y = 0;
            m_fs_total++;
        end else if (m_prev_act > 0) begin
            m_y++;
        end
        e.period = m_period;
        e.lck = (m_run >= LOCK_LINES);
        e.y = m_y;
        e.fs = vfall;
        exp_q.push_back(e);
        if (e.lck && act > 0) exp_run_q.push_back('{0, act, 1'b1, m_y});
        // A line with no following fall for more than two nominal periods drops lock.
        if (len > 2 * LINE_NOM + 1) begin
            if (m_run >= LOCK_LINES) m_err_total++;
            m_have_prev = 0;
            m_run = 0;
        end
        m_prev_len = len;
        m_prev_sw = sw;
        m_prev_act = act;
        m_prev_vs = vs;
    endtask

    task automatic drive_line(input int sw, input int act, input bit vs, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            h_sync = (i < sw) ? 1'b0 : 1'b1;
            v_sync = vs;
            bright = (i >= ACT_START && i < ACT_START + act);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_line(input int len, input int sw, input int act, input bit vs);
        model_line_start(len, sw, act, vs);
        drive_line(sw, act, vs, len);
    endtask

    task automatic check_events(input string tag);
        ev_t  e, o;
        run_t er, orr;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s line_start_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks += 5;
            if (o.period != e.period) begin
                errors++;
                $display("FAIL %s line_period: got %0d expected %0d", tag, o.period, e.period);
            end
            if (o.lck != e.lck) begin
                errors++;
                $display("FAIL %s locked: got %0d expected %0d", tag, o.lck, e.lck);
            end
            if (o.err != e.err) begin
                errors++;
                $display("FAIL %s err_at_line_start: got %0d expected %0d", tag, o.err, e.err);
            end
            if (o.y != e.y) begin
                errors++;
                $display("FAIL %s pix_y: got %0d expected %0d", tag, o.y, e.y);
            end
            if (o.fs != e.fs) begin
                errors++;
                $display("FAIL %s frame_start: got %0d expected %0d", tag, o.fs, e.fs);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (obs_run_q.size() != exp_run_q.size()) begin
            errors++;
            $display("FAIL %s pixel_run_count: got %0d expected %0d", tag, obs_run_q.size(), exp_run_q.size());
        end
        while (exp_run_q.size() > 0 && obs_run_q.size() > 0) begin
            er = exp_run_q.pop_front();
            orr = obs_run_q.pop_front();
            checks += 4;
            if (orr.first_x != er.first_x) begin
                errors++;
                $display("FAIL %s pix_x_first: got %0d expected %0d", tag, orr.first_x, er.first_x);
            end
            if (orr.len != er.len) begin
                errors++;
                $display("FAIL %s pixel_run_len: got %0d expected %0d", tag, orr.len, er.len);
            end
            if (orr.ok != er.ok) begin
                errors++;
                $display("FAIL %s pix_x_step: got %0d expected %0d", tag, orr.ok, er.ok);
            end
            if (orr.y != er.y) begin
                errors++;
                $display("FAIL %s pix_y_in_line: got %0d expected %0d", tag, orr.y, er.y);
            end
        end
        exp_run_q.delete();
        obs_run_q.delete();
        checks += 2;
        if (obs_err_cnt != m_err_total) begin
            errors++;
            $display("FAIL %s err_line_pulses: got %0d expected %0d", tag, obs_err_cnt, m_err_total);
        end
        if (obs_fs_cnt != m_fs_total) begin
            errors++;
            $display("FAIL %s frame_start_pulses: got %0d expected %0d", tag, obs_fs_cnt, m_fs_total);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks += 9;
        if (pix_x !== '0) begin errors++; $display("FAIL %s pix_x: got %0d expected 0", tag, pix_x); end
        if (pix_y !== '0) begin errors++; $display("FAIL %s pix_y: got %0d expected 0", tag, pix_y); end
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL %s pix_valid: got %b expected 0", tag, pix_valid); end
        if (line_start !== 1'b0) begin errors++; $display("FAIL %s line_start: got %b expected 0", tag, line_start); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL %s frame_start: got %b expected 0", tag, frame_start); end
        if (locked !== 1'b0) begin errors++; $display("FAIL %s locked: got %b expected 0", tag, locked); end
        if (line_period !== '0) begin errors++; $display("FAIL %s line_period: got %0d expected 0", tag, line_period); end
        if (err_line !== 1'b0) begin errors++; $display("FAIL %s err_line: got %b expected 0", tag, err_line); end
        if (dut.state_q !== vga_timing_pkg::SEARCH) begin
            errors++;
            $display("FAIL %s state: got %0d expected SEARCH", tag, dut.state_q);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        drive_line(0, 0, 1'b1, 6);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release line_start_count: got %0d expected 0", obs_q.size());
        end
    endtask

    task automatic test_nominal();
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < 8; l++) begin
                send_line(LINE_NOM, SYNC_NOM, (l >= 3 && l <= 6) ? ACT_NOM : 0, (l < 2) ? 1'b0 : 1'b1);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL nominal_locked: got %b expected 1", locked);
        end
        check_events("nominal");
    endtask

    task automatic test_stretch();
        send_line(LINE_NOM + 1, SYNC_NOM, ACT_NOM, 1'b1);
        for (int i = 0; i < 5; i++) send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        check_events("stretch");
    endtask

    task automatic test_narrow_sync();
        send_line(LINE_NOM, SYNC_NOM - 1, ACT_NOM, 1'b1);
        for (int i = 0; i < 5; i++) send_line(LINE_NOM, SYNC_NOM, 0, 1'b1);
        check_events("narrow_sync");
    endtask

    task automatic test_timeout();
        send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        send_line(1700, SYNC_NOM, 0, 1'b1);
        checks += 2;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_locked: got %b expected 0", locked);
        end
        if (dut.state_q !== vga_timing_pkg::SEARCH) begin
            errors++;
            $display("FAIL timeout_state: got %0d expected SEARCH", dut.state_q);
        end
        send_line(810, SYNC_NOM, 0, 1'b1);
        for (int i = 0; i < 6; i++) send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        check_events("timeout");
    endtask

    task automatic test_coincident();
        send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        send_line(LINE_NOM, SYNC_NOM, 0, 1'b0);
        send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        check_events("coincident");
    endtask

    task automatic test_random();
        int len, sw, act, kind;
        bit vs;
        for (int n = 0; n < 24; n++) begin
            len = LINE_NOM;
            sw = SYNC_NOM;
            act = ACT_NOM;
            vs = 1'b1;
            kind = $urandom_range(0, 9);
            case (kind)
                5: act = 0;
                6: len = $urandom_range(795, 805);
                7: sw = $urandom_range(94, 98);
                8: act = $urandom_range(636, 644);
                9: begin
                    vs = 1'b0;
                    act = ($urandom_range(0, 1) == 1) ? ACT_NOM : 0;
                end
                default: ;
            endcase
            send_line(len, sw, act, vs);
        end
        check_events("random");
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 5; i++) send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_locked: got %b expected 1", locked);
        end
        model_line_start(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        drive_line(SYNC_NOM, ACT_NOM, 1'b1, 300);
        if (exp_run_q.size() > 0) void'(exp_run_q.pop_back());
        check_events("pre_reset");
        h_sync = 1'b1;
        v_sync = 1'b1;
        bright = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midline_reset");
        reset = 1'b1;
        model_reset();
        drive_line(0, 0, 1'b1, 400);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midline_release line_start_count: got %0d expected 0", obs_q.size());
        end
        for (int i = 0; i < 6; i++) send_line(LINE_NOM, SYNC_NOM, ACT_NOM, 1'b1);
        check_events("post_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_err_total = 0;
        m_fs_total = 0;
        model_reset();
        h_sync = 1'b1;
        v_sync = 1'b1;
        bright = 1'b0;
        reset = 1'b0;
        test_reset();
        test_nominal();
        test_stretch();
        test_narrow_sync();
        test_timeout();
        test_coincident();
        test_random();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
